// File: rtl/syn_current_acc_pkg.sv
// -----------------------------------------------------------------------------
// syn_current_acc_pkg
//  Shared constants for the synaptic current accumulator and its weight store:
//  default widths, neuron-side constants and FSM state encodings.
// -----------------------------------------------------------------------------
package syn_current_acc_pkg;

   localparam int N_PRE_DEF = 16;
   localparam int W_W_DEF   = 6;
   localparam int I_W_DEF   = 9;
   localparam int ACC_W_DEF = 13;

   // neuron-side constants shared with the QIF block
   localparam int I_IN  = 9;
   localparam int V_TH  = 8;
   localparam int PARAM = 3;

   typedef logic [1:0] st_t;

   localparam st_t ST_ACCEPT  = 2'd0;
   localparam st_t ST_DRAIN   = 2'd1;
   localparam st_t ST_PUBLISH = 2'd2;

endpackage

// File: rtl/syn_weight_ram.sv
// -----------------------------------------------------------------------------
// syn_weight_ram
//  N_PRE x W_W weight register file, one write port, one registered read port.
//  A read and a write on the same edge to the same index return the old value
//  while the write still lands. Out-of-range indices read as 0, writes ignored.
// Ports
//  clk    in  clock
//  we     in  write enable
//  waddr  in  write index
//  wdata  in  write data
//  re     in  read enable (captures mem[raddr] into rdata on the edge)
//  raddr  in  read index
//  rdata  out registered read data
// -----------------------------------------------------------------------------
module syn_weight_ram
   import syn_current_acc_pkg::*;
#(
   parameter int N_PRE = N_PRE_DEF,
   parameter int AW    = $clog2(N_PRE),
   parameter int W_W   = W_W_DEF
) (
   input  logic           clk,
   input  logic           we,
   input  logic [AW-1:0]  waddr,
   input  logic [W_W-1:0] wdata,
   input  logic           re,
   input  logic [AW-1:0]  raddr,
   output logic [W_W-1:0] rdata
);

   logic [W_W-1:0] mem_q [N_PRE];
   logic [W_W-1:0] mem_d [N_PRE];
   logic [W_W-1:0] rdata_q;
   logic [W_W-1:0] rdata_d;

   always_comb begin
      mem_d   = mem_q;
      rdata_d = rdata_q;
      if (we && (int'(waddr) < N_PRE)) begin
         mem_d[waddr] = wdata;
      end
      // read from the pre-write array: old value on a same-index collision
      if (re) begin
         rdata_d = (int'(raddr) < N_PRE) ? mem_q[raddr] : '0;
      end
   end

   always_ff @(posedge clk) begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/syn_current_acc.sv
// -----------------------------------------------------------------------------
// syn_current_acc
//  Synaptic current accumulator feeding the QIF neuron's neu_in. Address-event
//  spikes look up a signed weight; weights are summed (saturating) over one
//  timestep and the clamped sum is published on each tick.
//  Optional feature macro: SYN_DECAY_EN -- when defined, the accumulator keeps
//  half of its value (arithmetic shift) into the next timestep; otherwise each
//  timestep starts from zero.
// Ports
//  clk         in   clock
//  rst         in   synchronous active-low reset (weights are kept)
//  wt_we       in   weight write enable (any state)
//  wt_addr     in   weight write index
//  wt_wdata    in   signed weight
//  spk_valid   in   spike event valid
//  spk_addr    in   pre-synaptic index of spike
//  spk_ready   out  spike can be accepted this cycle
//  tick        in   timestep boundary strobe
//  neu_in      out  clamped current, held between publishes
//  neu_in_vld  out  one-cycle pulse when neu_in updates
//  tick_drop   out  sticky: tick seen outside ACCEPT
//
//  state   | meaning
//  ACCEPT  | spikes accepted; tick closes the timestep
//  DRAIN   | no spikes; wait for the read/add pipeline to empty
//  PUBLISH | neu_in <= clamp(acc), pulse neu_in_vld, acc <= residual
// -----------------------------------------------------------------------------
module syn_current_acc
   import syn_current_acc_pkg::*;
#(
   parameter int N_PRE = N_PRE_DEF,
   parameter int W_W   = W_W_DEF,
   parameter int I_W   = I_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int AW    = $clog2(N_PRE)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wt_we,
   input  logic [AW-1:0]  wt_addr,
   input  logic [W_W-1:0] wt_wdata,
   input  logic           spk_valid,
   input  logic [AW-1:0]  spk_addr,
   output logic           spk_ready,
   input  logic           tick,
   output logic [I_W-1:0] neu_in,
   output logic           neu_in_vld,
   output logic           tick_drop
);

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   st_t            state_q,      state_d;
   logic           s1_vld_q,     s1_vld_d;
   logic           s2_vld_q,     s2_vld_d;
   logic [ACC_W-1:0] s2_w_q,     s2_w_d;
   logic [ACC_W-1:0] acc_q,      acc_d;
   logic [I_W-1:0] neu_in_q,     neu_in_d;
   logic           neu_in_vld_q, neu_in_vld_d;
   logic           tick_drop_q,  tick_drop_d;

   logic           spk_hs;
   logic [W_W-1:0] rd_w;
   logic [ACC_W:0] acc_sum;
   logic [ACC_W-1:0] acc_sat;
   logic [ACC_W-1:0] acc_resid;

   function automatic logic [I_W-1:0] clamp_cur(input logic [ACC_W-1:0] a);
      if (a[ACC_W-1]) begin
         clamp_cur = '0;
      end else if (|a[ACC_W-2:I_W]) begin
         clamp_cur = '1;
      end else begin
         clamp_cur = a[I_W-1:0];
      end
   endfunction

   assign spk_ready = (state_q == ST_ACCEPT);
   assign spk_hs    = spk_valid & spk_ready;

   // stage 1: weight read registered on the handshake edge
   syn_weight_ram #(
      .N_PRE (N_PRE),
      .AW    (AW),
      .W_W   (W_W)
   ) u_wram (
      .clk   (clk),
      .we    (wt_we),
      .waddr (wt_addr),
      .wdata (wt_wdata),
      .re    (spk_hs),
      .raddr (spk_addr),
      .rdata (rd_w)
   );

   always_comb begin
      // one extra bit of headroom; overflow shows as the top two bits differing
      acc_sum = {acc_q[ACC_W-1], acc_q} + {s2_w_q[ACC_W-1], s2_w_q};
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
         acc_sat = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_sat = acc_sum[ACC_W-1:0];
      end
`ifdef SYN_DECAY_EN
      acc_resid = $signed(acc_q) >>> 1;
`else
      acc_resid = '0;
`endif
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      neu_in_d     = neu_in_q;
      neu_in_vld_d = 1'b0;
      tick_drop_d  = tick_drop_q;
      s1_vld_d     = spk_hs;
      s2_vld_d     = s1_vld_q;
      s2_w_d       = s2_w_q;

      if (s1_vld_q) begin
         s2_w_d = {{(ACC_W-W_W){rd_w[W_W-1]}}, rd_w};
      end
      if (s2_vld_q) begin
         acc_d = acc_sat;
      end

      case (state_q)
         ST_ACCEPT: begin
            if (tick) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (tick) begin
               tick_drop_d = 1'b1;
            end
            // stage 2 is absorbed on this same edge, so only stage 1 gates exit
            if (!s1_vld_q) begin
               state_d = ST_PUBLISH;
            end
         end
         ST_PUBLISH: begin
            if (tick) begin
               tick_drop_d = 1'b1;
            end
            neu_in_d     = clamp_cur(acc_q);
            neu_in_vld_d = 1'b1;
            acc_d        = acc_resid;
            state_d      = ST_ACCEPT;
         end
         default: begin
            state_d = ST_ACCEPT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_ACCEPT;
         acc_q        <= '0;
         neu_in_q     <= '0;
         neu_in_vld_q <= 1'b0;
         tick_drop_q  <= 1'b0;
         s1_vld_q     <= 1'b0;
         s2_vld_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         neu_in_q     <= neu_in_d;
         neu_in_vld_q <= neu_in_vld_d;
         tick_drop_q  <= tick_drop_d;
         s1_vld_q     <= s1_vld_d;
         s2_vld_q     <= s2_vld_d;
      end
   end

   // data-only stage, qualified by s2_vld_q
   always_ff @(posedge clk) begin
      s2_w_q <= s2_w_d;
   end

   assign neu_in     = neu_in_q;
   assign neu_in_vld = neu_in_vld_q;
   assign tick_drop  = tick_drop_q;

endmodule

// File: tb/tb_syn_current_acc.sv
// -----------------------------------------------------------------------------
// tb_syn_current_acc
//  Directed + randomized bench for syn_current_acc with a behavioural model:
//  an integer weight table and an integer running sum with saturation/clamp.
// -----------------------------------------------------------------------------
module tb_syn_current_acc;

   logic       clk = 1'b0;
   logic       rst;
   logic       wt_we;
   logic [3:0] wt_addr;
   logic [5:0] wt_wdata;
   logic       spk_valid;
   logic [3:0] spk_addr;
   logic       spk_ready;
   logic       tick;
   logic [8:0] neu_in;
   logic       neu_in_vld;
   logic       tick_drop;

   int checks = 0;
   int errors = 0;
   int vld_pulses = 0;

   int wm [16];
   int accm;

   syn_current_acc dut (
      .clk        (clk),
      .rst        (rst),
      .wt_we      (wt_we),
      .wt_addr    (wt_addr),
      .wt_wdata   (wt_wdata),
      .spk_valid  (spk_valid),
      .spk_addr   (spk_addr),
      .spk_ready  (spk_ready),
      .tick       (tick),
      .neu_in     (neu_in),
      .neu_in_vld (neu_in_vld),
      .tick_drop  (tick_drop)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (neu_in_vld === 1'b1) vld_pulses++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int sat(input int a);
      if (a > 4095)  return 4095;
      if (a < -4096) return -4096;
      return a;
   endfunction

   function automatic int clampm(input int a);
      if (a < 0)   return 0;
      if (a > 511) return 511;
      return a;
   endfunction

   function automatic int sext6(input int v);
      int t;
      t = v & 63;
      return (t >= 32) ? t - 64 : t;
   endfunction

   function automatic int resid(input int a);
`ifdef SYN_DECAY_EN
      return a >>> 1;
`else
      return 0 * a;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one clock cycle of stimulus; the model applies the spike (old weight) before the write
   task automatic cyc(input logic we, input int wa, input int wd,
                      input logic sv, input int sa, input logic tk);
      wt_we     = we;
      wt_addr   = wa[3:0];
      wt_wdata  = wd[5:0];
      spk_valid = sv;
      spk_addr  = sa[3:0];
      tick      = tk;
      if (sv) begin
         check("spk_ready", {31'd0, spk_ready}, 1);
         accm = sat(accm + wm[sa]);
      end
      if (we) wm[wa] = sext6(wd);
      @(posedge clk);
      #1;
      wt_we     = 1'b0;
      spk_valid = 1'b0;
      tick      = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0, 0, 1'b0);
   endtask

   // lat counts edges with the tick edge as 1; an idle pipeline publishes on edge 3
   task automatic do_tick(input logic sv, input int sa, input logic dbl, input logic strict);
      int lat;
      int exp_n;
      cyc(1'b0, 0, 0, sv, sa, 1'b1);
      lat = 1;
      check("vld_early", {31'd0, neu_in_vld}, 0);
      if (dbl) begin
         cyc(1'b0, 0, 0, 1'b0, 0, 1'b1);
         lat = 2;
      end
      while (neu_in_vld !== 1'b1 && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
      end
      exp_n = clampm(accm);
      if (strict) check("tick_lat", lat, 3);
      else        check("tick_lat_range", {31'd0, (lat >= 3 && lat <= 4)}, 1);
      check("neu_in", {23'd0, neu_in}, exp_n);
      accm = resid(accm);
      @(posedge clk);
      #1;
      check("vld_width", {31'd0, neu_in_vld}, 0);
      check("neu_in_hold", {23'd0, neu_in}, exp_n);
   endtask

   initial begin
      int p0;
      int n;
      int idx;
      rst = 1'b0; wt_we = 1'b0; wt_addr = '0; wt_wdata = '0;
      spk_valid = 1'b0; spk_addr = '0; tick = 1'b0;
      accm = 0;
      for (int i = 0; i < 16; i++) wm[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_neu_in", {23'd0, neu_in}, 0);
      check("rst_vld", {31'd0, neu_in_vld}, 0);
      check("rst_drop", {31'd0, tick_drop}, 0);
      check("rst_ready", {31'd0, spk_ready}, 1);
      rst = 1'b1;
      for (int i = 0; i < 16; i++) cyc(1'b1, i, 0, 1'b0, 0, 1'b0);

      // 1: 4 x (+5)
      cyc(1'b1, 3, 5, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b1, 3, 1'b0);
      do_tick(1'b0, 0, 1'b0, 1'b0);

      // 2: negative clamp
      cyc(1'b1, 1, -20, 1'b0, 0, 1'b0);
      cyc(1'b1, 2, 7, 1'b0, 0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 2, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 1, 1'b0);
      idle(3);
      do_tick(1'b0, 0, 1'b0, 1'b1);

      // 3: upper clamp, then saturation (wrap would go negative and clamp to 0)
      cyc(1'b1, 0, 31, 1'b0, 0, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b0, 0, 0, 1'b1, 0, 1'b0);
      do_tick(1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) cyc(1'b0, 0, 0, 1'b1, 0, 1'b0);
      do_tick(1'b0, 0, 1'b0, 1'b0);
      check("sat_511", {23'd0, neu_in}, 511);

      // 4: spike on the tick edge counts; second tick dropped
      cyc(1'b1, 6, 3, 1'b0, 0, 1'b0);
      idle(3);
      accm = 0 + resid(accm) * 0 + accm;
      cyc(1'b0, 0, 0, 1'b1, 6, 1'b0);
      p0 = vld_pulses;
      check("drop_pre", {31'd0, tick_drop}, 0);
      do_tick(1'b1, 6, 1'b1, 1'b0);
      idle(4);
      check("drop_set", {31'd0, tick_drop}, 1);
      check("one_publish", vld_pulses - p0, 1);

      // 5: decay sequence (empty ticks)
      cyc(1'b1, 5, 20, 1'b0, 0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 1'b1, 5, 1'b0);
      do_tick(1'b0, 0, 1'b0, 1'b0);
      idle(2);
      do_tick(1'b0, 0, 1'b0, 1'b1);
      idle(2);
      do_tick(1'b0, 0, 1'b0, 1'b1);

      // 6: reset mid-timestep, then read-before-write collision
      cyc(1'b1, 4, 2, 1'b0, 0, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 5, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 4, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      accm = 0;
      check("mid_rst_neu_in", {23'd0, neu_in}, 0);
      check("mid_rst_ready", {31'd0, spk_ready}, 1);
      check("mid_rst_drop", {31'd0, tick_drop}, 0);
      check("mid_rst_vld", {31'd0, neu_in_vld}, 0);
      idle(3);
      check("no_publish_after_rst", {31'd0, neu_in_vld}, 0);
      cyc(1'b1, 4, 9, 1'b1, 4, 1'b0);
      cyc(1'b0, 0, 0, 1'b1, 4, 1'b0);
      idle(3);
      do_tick(1'b0, 0, 1'b0, 1'b1);
      check("rbw_sum_11", {23'd0, neu_in}, 11);

      // randomized timesteps
      for (int ts = 0; ts < 8; ts++) begin
         n = int'($urandom_range(0, 30));
         for (int i = 0; i < n; i++) begin
            idx = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
               cyc(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 63)), 1'b0, 0, 1'b0);
            else if ($urandom_range(0, 5) == 0)
               cyc(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 63)), 1'b1, idx, 1'b0);
            else
               cyc(1'b0, 0, 0, 1'b1, idx, 1'b0);
         end
         do_tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
